// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART frame parser:
//   - FSM state encoding (legacy-compatible localparam constants)
//   - error cause codes reported on o_err_code
//   - default frame-start marker
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_HUNT    = 3'd0;
  localparam state_t ST_ADDR    = 3'd1;
  localparam state_t ST_LEN     = 3'd2;
  localparam state_t ST_PAYLOAD = 3'd3;
  localparam state_t ST_CSUM    = 3'd4;
  localparam state_t ST_DRAIN   = 3'd5;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// ---------------------------------------------------------------------------
// uart_frame_buf
// Payload buffer: DEPTH x 8 register file, one synchronous write port and
// one combinational read port.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
// ---------------------------------------------------------------------------
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: the storage array has no reset; every location is written before
  // it can be read, and resetting a memory costs a mux per bit.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_frame_parser
// Assembles frames of the form SYNC, ADDR, LEN, PAYLOAD[LEN], CSUM from the
// UART receiver byte stream. CSUM is the XOR of ADDR, LEN and all payload
// bytes. Good frames are drained over a valid/ready byte stream; bad,
// oversize or stalled frames are dropped with a one-cycle error pulse.
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_rx_bus, i_rx_hs     : received byte and its one-cycle done strobe
//   o_frame_valid         : high for the whole drain of a good frame
//   o_frame_addr/len      : header of the frame being drained
//   o_data, o_data_valid,
//   i_data_ready,
//   o_data_last           : payload byte stream
//   o_err, o_err_code     : error pulse and held cause code
//   o_overrun             : pulse when a byte arrives during a drain
// ---------------------------------------------------------------------------
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 52080
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_bus,
  input  logic       i_rx_hs,
  output logic       o_frame_valid,
  output logic [7:0] o_frame_addr,
  output logic [7:0] o_frame_len,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  input  logic       i_data_ready,
  output logic       o_data_last,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic       o_overrun
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);

  state_t           state;
  logic [7:0]       addr_q;
  logic [7:0]       len_q;
  logic [7:0]       csum_q;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] rd;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic [1:0]       err_code_q;
  logic             overrun_q;

  logic             in_frame;
  logic             draining;
  logic             timeout_hit;
  logic             len_ok;
  logic [7:0]       len_last;
  logic             idx_last;
  logic             rd_last;
  logic             beat;
  logic             buf_we;
  logic [7:0]       buf_rdata;

  assign in_frame = (state == ST_ADDR) || (state == ST_LEN) ||
                    (state == ST_PAYLOAD) || (state == ST_CSUM);
  assign draining = (state == ST_DRAIN);

  // Fires on the TIMEOUT_CLKS-th consecutive idle clock inside a frame; a
  // byte arriving in that same cycle takes priority.
  assign timeout_hit = in_frame && !i_rx_hs &&
                       (cnt == CNT_W'(TIMEOUT_CLKS - 1));

  assign len_ok   = (i_rx_bus != 8'h00) && (i_rx_bus <= 8'(MAX_LEN));
  assign len_last = len_q - 8'd1;
  assign idx_last = (8'(idx) == len_last);
  assign rd_last  = (8'(rd) == len_last);
  assign beat     = draining && i_data_ready;
  assign buf_we   = (state == ST_PAYLOAD) && i_rx_hs;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (IDX_W)
  ) u_buf (
    .clk   (i_clk),
    .we    (buf_we),
    .waddr (idx),
    .wdata (i_rx_bus),
    .raddr (rd),
    .rdata (buf_rdata)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_HUNT;
      addr_q     <= 8'h00;
      len_q      <= 8'h00;
      csum_q     <= 8'h00;
      idx        <= '0;
      rd         <= '0;
      cnt        <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      overrun_q  <= 1'b0;
    end else begin
      err_q     <= 1'b0;
      overrun_q <= 1'b0;

      // Idle counter only advances between bytes of a frame being collected.
      if (!in_frame || i_rx_hs || timeout_hit) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (timeout_hit) begin
        state      <= ST_HUNT;
        err_q      <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
      end else begin
        case (state)
          ST_HUNT: begin
            if (i_rx_hs && (i_rx_bus == SYNC_BYTE)) begin
              state <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            if (i_rx_hs) begin
              addr_q <= i_rx_bus;
              csum_q <= i_rx_bus;
              state  <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (i_rx_hs) begin
              if (!len_ok) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_LEN;
                state      <= ST_HUNT;
              end else begin
                len_q  <= i_rx_bus;
                csum_q <= csum_q ^ i_rx_bus;
                idx    <= '0;
                state  <= ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            // A sync-valued byte here is plain data; no mid-frame resync.
            if (i_rx_hs) begin
              csum_q <= csum_q ^ i_rx_bus;
              if (idx_last) begin
                state <= ST_CSUM;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
          ST_CSUM: begin
            if (i_rx_hs) begin
              if (i_rx_bus == csum_q) begin
                rd    <= '0;
                state <= ST_DRAIN;
              end else begin
                err_q      <= 1'b1;
                err_code_q <= ERR_CSUM;
                state      <= ST_HUNT;
              end
            end
          end
          ST_DRAIN: begin
            if (i_rx_hs) begin
              overrun_q <= 1'b1;
            end
            if (beat) begin
              if (rd_last) begin
                state <= ST_HUNT;
              end else begin
                rd <= rd + 1'b1;
              end
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  assign o_frame_valid = draining;
  assign o_data_valid  = draining;
  // Gate the read port so o_data reads 8'h00 outside a drain, including
  // right after reset when the buffer holds unknown contents.
  assign o_data        = draining ? buf_rdata : 8'h00;
  assign o_data_last   = draining && rd_last;
  assign o_frame_addr  = addr_q;
  assign o_frame_len   = len_q;
  assign o_err         = err_q;
  assign o_err_code    = err_code_q;
  assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_parser
// Self-checking bench for uart_frame_parser: a table of directed frames with
// hand-computed results, plus hand-written sequences for timeout,
// backpressure/overrun, maximum length and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_uart_frame_parser;
  import uart_pkg::*;

  localparam int MAX_LEN      = 16;
  localparam int TIMEOUT_CLKS = 40;
  localparam int NV           = 7;

  typedef logic [7:0] byte_q_t[$];

  // Byte sequences are written MSB-first: the leftmost byte is sent first.
  typedef struct packed {
    logic [63:0] seq;
    logic [3:0]  n;
    logic        good;
    logic [1:0]  code;
    logic [7:0]  addr;
    logic [7:0]  len;
    logic [31:0] data;
  } vec_t;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_rx_bus;
  logic       i_rx_hs;
  logic       o_frame_valid;
  logic [7:0] o_frame_addr;
  logic [7:0] o_frame_len;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       i_data_ready;
  logic       o_data_last;
  logic       o_err;
  logic [1:0] o_err_code;
  logic       o_overrun;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  uart_frame_parser #(
    .SYNC_BYTE    (8'hA5),
    .MAX_LEN      (MAX_LEN),
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_rx_bus      (i_rx_bus),
    .i_rx_hs       (i_rx_hs),
    .o_frame_valid (o_frame_valid),
    .o_frame_addr  (o_frame_addr),
    .o_frame_len   (o_frame_len),
    .o_data        (o_data),
    .o_data_valid  (o_data_valid),
    .i_data_ready  (i_data_ready),
    .o_data_last   (o_data_last),
    .o_err         (o_err),
    .o_err_code    (o_err_code),
    .o_overrun     (o_overrun)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  function automatic byte_q_t mkq(input logic [63:0] seq, input int n);
    byte_q_t q;
    q = {};
    for (int i = 0; i < n; i++) q.push_back(seq[63-8*i -: 8]);
    return q;
  endfunction

  // Present one byte with its strobe for one cycle; returns on the negedge
  // after the consuming posedge, where registered responses are visible.
  task automatic send_byte(input logic [7:0] b);
    i_rx_bus = b;
    i_rx_hs  = 1'b1;
    tick();
    i_rx_hs  = 1'b0;
    i_rx_bus = 8'h00;
  endtask

  task automatic send_seq(input string tag, input byte_q_t s);
    for (int i = 0; i < s.size(); i++) begin
      send_byte(s[i]);
      if (i < s.size() - 1) begin
        check($sformatf("%s mid err[%0d]", tag, i), 32'(o_err), 0);
        check($sformatf("%s mid valid[%0d]", tag, i), 32'(o_frame_valid), 0);
      end
    end
  endtask

  task automatic expect_good(input string tag, input logic [7:0] addr,
                             input logic [7:0] len, input byte_q_t d);
    check({tag, " frame_valid"}, 32'(o_frame_valid), 1);
    check({tag, " no err"}, 32'(o_err), 0);
    check({tag, " addr"}, 32'(o_frame_addr), 32'(addr));
    check({tag, " len"}, 32'(o_frame_len), 32'(len));
    for (int k = 0; k < d.size(); k++) begin
      check($sformatf("%s data_valid[%0d]", tag, k), 32'(o_data_valid), 1);
      check($sformatf("%s data[%0d]", tag, k), 32'(o_data), 32'(d[k]));
      check($sformatf("%s last[%0d]", tag, k), 32'(o_data_last),
            (k == d.size() - 1) ? 1 : 0);
      tick();
    end
    check({tag, " frame_valid drop"}, 32'(o_frame_valid), 0);
  endtask

  task automatic expect_err(input string tag, input logic [1:0] code);
    check({tag, " err pulse"}, 32'(o_err), 1);
    check({tag, " err code"}, 32'(o_err_code), 32'(code));
    check({tag, " no frame"}, 32'(o_frame_valid), 0);
    tick();
    check({tag, " err one cycle"}, 32'(o_err), 0);
    check({tag, " code held"}, 32'(o_err_code), 32'(code));
  endtask

  vec_t    vecs [NV];
  byte_q_t s;
  byte_q_t d;
  logic    saw;
  logic [7:0] cs;

  initial begin
    vecs[0] = '{seq: 64'hA5_03_02_11_22_32_00_00, n: 4'd6, good: 1'b1,
                code: 2'd0, addr: 8'h03, len: 8'h02, data: 32'h11_22_00_00};
    vecs[1] = '{seq: 64'hA5_03_02_11_22_33_00_00, n: 4'd6, good: 1'b0,
                code: ERR_CSUM, addr: 8'h00, len: 8'h00, data: 32'h0};
    vecs[2] = vecs[0];
    vecs[3] = '{seq: 64'hA5_07_00_00_00_00_00_00, n: 4'd3, good: 1'b0,
                code: ERR_LEN, addr: 8'h00, len: 8'h00, data: 32'h0};
    vecs[4] = '{seq: 64'hA5_07_11_00_00_00_00_00, n: 4'd3, good: 1'b0,
                code: ERR_LEN, addr: 8'h00, len: 8'h00, data: 32'h0};
    // Leading junk byte, then a payload that itself contains the sync value.
    vecs[5] = '{seq: 64'h3C_A5_10_03_A5_00_FF_49, n: 4'd8, good: 1'b1,
                code: 2'd0, addr: 8'h10, len: 8'h03, data: 32'hA5_00_FF_00};
    vecs[6] = '{seq: 64'hA5_42_01_7E_3D_00_00_00, n: 4'd5, good: 1'b1,
                code: 2'd0, addr: 8'h42, len: 8'h01, data: 32'h7E_00_00_00};

    i_rst        = 1'b1;
    i_rx_bus     = 8'h00;
    i_rx_hs      = 1'b0;
    i_data_ready = 1'b1;
    tick();
    tick();

    // Reset values.
    check("rst frame_valid", 32'(o_frame_valid), 0);
    check("rst data_valid", 32'(o_data_valid), 0);
    check("rst data_last", 32'(o_data_last), 0);
    check("rst err", 32'(o_err), 0);
    check("rst err_code", 32'(o_err_code), 0);
    check("rst overrun", 32'(o_overrun), 0);
    check("rst addr", 32'(o_frame_addr), 0);
    check("rst len", 32'(o_frame_len), 0);
    check("rst data", 32'(o_data), 0);
    i_rst = 1'b0;

    // The idle counter must not run in HUNT.
    saw = 1'b0;
    for (int k = 0; k < 2 * TIMEOUT_CLKS; k++) begin
      tick();
      if (o_err) saw = 1'b1;
    end
    check("hunt idle no timeout", 32'(saw), 0);

    // Directed frame table.
    for (int v = 0; v < NV; v++) begin
      s = mkq(vecs[v].seq, int'(vecs[v].n));
      send_seq($sformatf("vec%0d", v), s);
      if (vecs[v].good) begin
        d = mkq({vecs[v].data, 32'h0}, int'(vecs[v].len));
        expect_good($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len, d);
      end else begin
        expect_err($sformatf("vec%0d", v), vecs[v].code);
      end
      tick();
    end

    // Maximum legal length frame.
    s = {8'hA5, 8'h01, 8'h10};
    d = {};
    cs = 8'h01 ^ 8'h10;
    for (int i = 0; i < MAX_LEN; i++) begin
      d.push_back(8'(i * 17 + 3));
      cs = cs ^ 8'(i * 17 + 3);
    end
    for (int i = 0; i < MAX_LEN; i++) s.push_back(d[i]);
    s.push_back(cs);
    send_seq("maxlen", s);
    expect_good("maxlen", 8'h01, 8'h10, d);
    tick();

    // Backpressure 1,0,0,1 with a byte injected while stalled, then an
    // immediate new sync right after the drain ends.
    // csum = 09^04^10^20^30^40 = 4D
    send_seq("bp", mkq(64'hA5_09_04_10_20_30_40_4D, 8));
    check("bp valid", 32'(o_frame_valid), 1);
    check("bp beat0", 32'(o_data), 'h10);
    i_data_ready = 1'b1;
    tick();
    check("bp beat1", 32'(o_data), 'h20);
    i_data_ready = 1'b0;
    i_rx_bus     = 8'h55;
    i_rx_hs      = 1'b1;
    tick();
    i_rx_hs  = 1'b0;
    i_rx_bus = 8'h00;
    check("bp hold data", 32'(o_data), 'h20);
    check("bp hold last", 32'(o_data_last), 0);
    check("bp overrun pulse", 32'(o_overrun), 1);
    tick();
    check("bp hold data 2", 32'(o_data), 'h20);
    check("bp overrun one cycle", 32'(o_overrun), 0);
    i_data_ready = 1'b1;
    tick();
    check("bp beat2", 32'(o_data), 'h30);
    tick();
    check("bp beat3", 32'(o_data), 'h40);
    check("bp last", 32'(o_data_last), 1);
    tick();
    check("bp valid drop", 32'(o_frame_valid), 0);
    send_seq("bp next", mkq(64'hA5_42_01_7E_3D_00_00_00, 5));
    d = {8'h7E};
    expect_good("bp next", 8'h42, 8'h01, d);
    tick();

    // Timeout: a gap of TIMEOUT_CLKS-1 idle clocks survives, TIMEOUT_CLKS
    // idle clocks does not.
    send_seq("to", mkq(64'hA5_03_00_00_00_00_00_00, 2));
    saw = 1'b0;
    for (int k = 0; k < TIMEOUT_CLKS - 1; k++) begin
      tick();
      if (o_err) saw = 1'b1;
    end
    send_byte(8'h02);
    if (o_err) saw = 1'b1;
    check("to gap T-1 no err", 32'(saw), 0);
    saw = 1'b0;
    for (int k = 0; k < TIMEOUT_CLKS - 1; k++) begin
      tick();
      if (o_err) saw = 1'b1;
    end
    check("to no early err", 32'(saw), 0);
    tick();
    expect_err("to", ERR_TIMEOUT);
    send_seq("to recover", mkq(64'hA5_03_02_11_22_32_00_00, 6));
    d = {8'h11, 8'h22};
    expect_good("to recover", 8'h03, 8'h02, d);
    tick();

    // Reset in the middle of the payload.
    send_seq("rst mid", mkq(64'hA5_03_02_11_00_00_00_00, 4));
    i_rst = 1'b1;
    #1;
    check("rst mid frame_valid", 32'(o_frame_valid), 0);
    check("rst mid err", 32'(o_err), 0);
    check("rst mid err_code", 32'(o_err_code), 0);
    check("rst mid addr", 32'(o_frame_addr), 0);
    check("rst mid len", 32'(o_frame_len), 0);
    check("rst mid data", 32'(o_data), 0);
    tick();
    i_rst = 1'b0;
    tick();
    check("rst mid no err after", 32'(o_err), 0);
    send_seq("rst after", mkq(64'hA5_03_02_11_22_32_00_00, 6));
    d = {8'h11, 8'h22};
    expect_good("rst after", 8'h03, 8'h02, d);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
